// File: rtl/sgc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sgc_pkg
//  Brief    : Shared constants and state type for the ADC frame receiver.
//  Revision : 1.0
// ============================================================================
package sgc_pkg;

  localparam int ADC_DATA_W    = 12;
  localparam int FSPI_PER_FADC = 12;
  localparam int CLKG_PER_FSPI = 8;

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    SHIFT     = 1'b1
  } sgc_state_t;

endpackage
`default_nettype wire

// File: rtl/sgc_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : sgc_edge_det
//  Brief    : Single-register rising-edge detector for CLK_G-synchronous levels.
//  Revision : 1.0
// ============================================================================
module sgc_edge_det (
  input  logic CLK_G,
  input  logic RST_S,
  input  logic SIG_IN,
  output logic RISE
);

  logic r_sig_d;

  always_ff @(posedge CLK_G) begin
    if (RST_S) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= SIG_IN;
    end
  end

  assign RISE = SIG_IN & ~r_sig_d;

endmodule
`default_nettype wire

// File: rtl/adc_frame_rx_sgc.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_rx_sgc
//  Brief    : IC003 serial ADC deserializer with chopper demodulation and
//             saturating malformed-frame counter.
//  Revision : 1.0
// ============================================================================
module adc_frame_rx_sgc
  import sgc_pkg::*;
#(
  parameter int DATA_W  = ADC_DATA_W,
  parameter bit CHOP_EN = 1'b1,
  parameter int ERR_W   = 8
) (
  input  logic             CLK_G,
  input  logic             RST_S,
  input  logic             SPI_EN,
  input  logic             FSPI,
  input  logic             FADC,
  input  logic             ADC_DOUT,
  output logic [DATA_W:0]  DATA_OUT,
  output logic             DATA_VLD,
  output logic             CH_PHASE,
  output logic             FRAME_ERR,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int               CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DATA_W);

  logic              r_dout_s1, r_dout_s2;
  logic              w_fspi_rise, w_fadc_rise;
  sgc_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_phase, w_phase_nxt;
  logic              w_phase_used;
  logic [DATA_W:0]   w_word_sx, w_demod, w_data_nxt;
  logic              w_vld_nxt, w_err_nxt, w_ch_phase_nxt;
  logic [ERR_W-1:0]  w_err_cnt_nxt;

  always_ff @(posedge CLK_G) begin
    if (RST_S) begin
      r_dout_s1 <= 1'b0;
      r_dout_s2 <= 1'b0;
    end else begin
      r_dout_s1 <= ADC_DOUT;
      r_dout_s2 <= r_dout_s1;
    end
  end

  sgc_edge_det u_fspi_edge (.CLK_G(CLK_G), .RST_S(RST_S), .SIG_IN(FSPI), .RISE(w_fspi_rise));
  sgc_edge_det u_fadc_edge (.CLK_G(CLK_G), .RST_S(RST_S), .SIG_IN(FADC), .RISE(w_fadc_rise));

  // Extra output bit keeps the negation of the most negative word representable
  assign w_phase_used = CHOP_EN & r_phase;
  assign w_word_sx    = {r_shreg[DATA_W-1], r_shreg};
  assign w_demod      = w_phase_used ? -w_word_sx : w_word_sx;

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_ovf_nxt      = r_ovf;
    w_phase_nxt    = r_phase;
    w_data_nxt     = DATA_OUT;
    w_ch_phase_nxt = CH_PHASE;
    w_err_cnt_nxt  = ERR_CNT;
    w_vld_nxt      = 1'b0;
    w_err_nxt      = 1'b0;

    if (SPI_EN) begin
      w_state_nxt   = SYNC_WAIT;
      w_bit_cnt_nxt = '0;
      w_shreg_nxt   = '0;
      w_ovf_nxt     = 1'b0;
    end else begin
      case (r_state)
        SYNC_WAIT: begin
          if (w_fadc_rise) begin
            w_state_nxt   = SHIFT;
            w_bit_cnt_nxt = '0;
            w_ovf_nxt     = 1'b0;
          end
        end
        SHIFT: begin
          if (w_fadc_rise) begin
            if ((r_bit_cnt == C_FULL) && !r_ovf) begin
              w_data_nxt     = w_demod;
              w_vld_nxt      = 1'b1;
              w_ch_phase_nxt = w_phase_used;
            end else begin
              w_err_nxt = 1'b1;
              if (ERR_CNT != {ERR_W{1'b1}}) begin
                w_err_cnt_nxt = ERR_CNT + 1'b1;
              end
            end
            if (CHOP_EN) begin
              w_phase_nxt = ~r_phase;
            end
            w_bit_cnt_nxt = '0;
            w_ovf_nxt     = 1'b0;
            // A coincident bit clock opens the next frame with its first bit
            if (w_fspi_rise) begin
              w_shreg_nxt   = {{(DATA_W-1){1'b0}}, r_dout_s2};
              w_bit_cnt_nxt = CNT_W'(1);
            end
          end else if (w_fspi_rise) begin
            if (r_bit_cnt < C_FULL) begin
              w_shreg_nxt   = {r_shreg[DATA_W-2:0], r_dout_s2};
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK_G) begin
    if (RST_S) begin
      r_state   <= SYNC_WAIT;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_ovf     <= 1'b0;
      r_phase   <= 1'b0;
      DATA_OUT  <= '0;
      DATA_VLD  <= 1'b0;
      CH_PHASE  <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_ovf     <= w_ovf_nxt;
      r_phase   <= w_phase_nxt;
      DATA_OUT  <= w_data_nxt;
      DATA_VLD  <= w_vld_nxt;
      CH_PHASE  <= w_ch_phase_nxt;
      FRAME_ERR <= w_err_nxt;
      ERR_CNT   <= w_err_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/adc_frame_rx_sgc.md
Name: adc_frame_rx_sgc

Overview:
- Downstream consumer of the CLK_G-domain clock bundle (FSPI, FADC) from the global clock generator.
- Deserializes the IC003 ADC serial output (MSB first, 12 bits per FADC period) into parallel words in the CLK_G domain.
- Applies chopper demodulation (sign alternates every frame) and flags malformed frames.
- Output feeds the CIC/Hadamard decode chain.

Parameters:
- DATA_W, 12, bits per ADC frame (= FSPI edges per FADC period).
- CHOP_EN, 1, 1 = alternate output sign per frame; 0 = pass-through.
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- CLK_G  input  1  system clock, 6.144 MHz; all logic on rising edge.
- RST_S  input  1  synchronous active-high reset.
- SPI_EN  input  1  high = configuration in progress; receiver held idle.
- FSPI  input  1  bit clock (CLK_G/8), CLK_G-synchronous level.
- FADC  input  1  frame clock (CLK_G/96), CLK_G-synchronous level.
- ADC_DOUT  input  1  serial ADC data from the IC, asynchronous.
- DATA_OUT  output  DATA_W+1  demodulated two's-complement sample.
- DATA_VLD  output  1  one-cycle strobe; DATA_OUT is valid in that cycle.
- CH_PHASE  output  1  chop phase applied to the current DATA_OUT (1 = negated).
- FRAME_ERR  output  1  one-cycle strobe on a malformed frame.
- ERR_CNT  output  ERR_W  saturating count of FRAME_ERR events.

Behaviour:
- Reset (RST_S=1 at a CLK_G edge) clears everything to 0: DATA_OUT, DATA_VLD, CH_PHASE, FRAME_ERR, ERR_CNT, the shift register, the bit counter, and the 2-FF ADC_DOUT synchronizer. State goes to SYNC_WAIT. Reset takes priority over all other inputs.
- ADC_DOUT passes through a 2-FF synchronizer. "Bit" below means the synchronizer output.
- Edge detection: each of FSPI and FADC is registered once. A rise is detected in the cycle where the registered value is 0 and the input is 1.
- SPI_EN=1 forces state to SYNC_WAIT and clears bit_cnt and the shift register. ERR_CNT and CH_PHASE are held. No DATA_VLD or FRAME_ERR is issued while SPI_EN=1.
- State SYNC_WAIT:
  - FSPI rises are ignored.
  - On the first FADC rise: go to SHIFT with bit_cnt=0. No output.
- State SHIFT, FSPI rise:
  - If bit_cnt<DATA_W: shift the bit into the LSB (MSB arrives first) and increment bit_cnt.
  - If bit_cnt=DATA_W: set the overflow flag and leave the shift register unchanged.
- State SHIFT, FADC rise (frame boundary):
  - If bit_cnt=DATA_W and no overflow:
    - Sign-extend the word to DATA_W+1 bits.
    - If CHOP_EN=1 and the phase is 1, DATA_OUT = 0 − word; otherwise DATA_OUT = word. The extra bit makes −(−2048)=+2048 representable.
    - DATA_VLD=1 for one cycle. CH_PHASE = the phase used. The phase then toggles (only when CHOP_EN=1).
  - Otherwise: FRAME_ERR=1 for one cycle and ERR_CNT increments, saturating at all-ones. DATA_OUT is held. The phase still toggles so chop alignment tracks the IC.
  - In both cases, clear bit_cnt and the overflow flag and start a new frame.
- FSPI rise and FADC rise in the same cycle: the boundary is processed first. The captured bit becomes bit 0 of the new frame (bit_cnt=1 afterwards).
- Latency: DATA_VLD/FRAME_ERR assert one CLK_G cycle after the cycle in which the FADC rise is detected.
- FADC rise with bit_cnt=0 counts as an error (empty frame).
- Between strobes, DATA_VLD=0 and FRAME_ERR=0; DATA_OUT and CH_PHASE hold their last values.

Decomposition:
- Shared package sgc_pkg holds:
  - ADC_DATA_W=12, FSPI_PER_FADC=12, CLKG_PER_FSPI=8.
  - The state typedef {SYNC_WAIT, SHIFT}.
- Sub-module sgc_edge_det (sync reset, 1-bit rise detector), instantiated for FSPI and FADC.
- The synchronizer and the demodulator live inline.

Test Plan:
- Reset, then 12 FSPI rises shifting 0xA5C followed by an FADC rise: no output for the first frame (SYNC_WAIT). The next valid frame 0x123 (CHOP_EN=1, phase 0) gives DATA_OUT=+291, CH_PHASE=0, DATA_VLD one cycle after the FADC rise. The following frame 0x123 gives DATA_OUT=−291, CH_PHASE=1.
- Frame 0x800 at phase 1 -> DATA_OUT=+2048 (13-bit 0x0800). The same word at phase 0 -> −2048 (0x1800).
- Frame with 11 bits, then a frame with 13 bits -> FRAME_ERR twice, ERR_CNT=2, no DATA_VLD. DATA_OUT keeps its previous value.
- 260 consecutive empty frames (ERR_W=8) -> ERR_CNT saturates at 255.
- SPI_EN pulsed high mid-frame after 6 bits -> no strobe. After SPI_EN falls, the first FADC rise only resyncs. The next 12-bit frame produces a valid word, and CH_PHASE continues from its held value.
- RST_S asserted in the same cycle as a frame-complete FADC rise -> no DATA_VLD. All outputs are 0 on the next cycle.
